// File: rtl/mod_exp_sequencer_if.sv
// Request/result and multiplier-facing signal bundle for mod_exp_sequencer.
// master: the sequencer itself; slave: the control side plus the multiplier.
interface mod_exp_sequencer_if #(
    parameter int unsigned WIDTH    = 256,
    parameter int unsigned EXP_BITS = 256
);
    logic                i_start;
    logic [WIDTH-1:0]    i_n;
    logic [WIDTH-1:0]    i_base;
    logic [EXP_BITS-1:0] i_exp;
    logic                o_busy;
    logic [WIDTH-1:0]    o_result;
    logic                o_finished;
    logic                o_mul_start;
    logic [WIDTH-1:0]    o_mul_a;
    logic [WIDTH-1:0]    o_mul_b;
    logic [WIDTH-1:0]    o_mul_n;
    logic [WIDTH-1:0]    i_mul_result;
    logic                i_mul_finished;

    modport master (
        input  i_start, i_n, i_base, i_exp, i_mul_result, i_mul_finished,
        output o_busy, o_result, o_finished, o_mul_start, o_mul_a, o_mul_b, o_mul_n
    );

    modport slave (
        output i_start, i_n, i_base, i_exp, i_mul_result, i_mul_finished,
        input  o_busy, o_result, o_finished, o_mul_start, o_mul_a, o_mul_b, o_mul_n
    );
endinterface

// File: rtl/mod_exp_sequencer.sv
// Left-to-right square-and-multiply sequencer driving one shared a*b mod n multiplier.
// Optional MODEXP_SKIP_LZ_EN: skip the exponent's leading zeros and start from acc=base.
module mod_exp_sequencer #(
    parameter int unsigned WIDTH    = 256,
    parameter int unsigned EXP_BITS = 256
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    mod_exp_sequencer_if.master  bus
);
    localparam int unsigned IDX_W = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SQ_ISSUE  = 3'd1,
        SQ_WAIT   = 3'd2,
        MUL_ISSUE = 3'd3,
        MUL_WAIT  = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t              state, state_d;
    logic [WIDTH-1:0]    acc, acc_d;
    logic [WIDTH-1:0]    n_q, n_d;
    logic [WIDTH-1:0]    base_q, base_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic [EXP_BITS-1:0] exp_q, exp_d;
    logic [IDX_W-1:0]    bit_idx, bit_idx_d;

`ifdef MODEXP_SKIP_LZ_EN
    logic [IDX_W-1:0]    hi_idx;
    logic                hi_found;

    // Highest set bit of the incoming exponent; later iterations overwrite earlier ones.
    always_comb begin
        hi_idx   = '0;
        hi_found = 1'b0;
        for (int unsigned i = 0; i < EXP_BITS; i++) begin
            if (bus.i_exp[i]) begin
                hi_idx   = IDX_W'(i);
                hi_found = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state    <= IDLE;
            acc      <= '0;
            n_q      <= '0;
            base_q   <= '0;
            result_q <= '0;
            exp_q    <= '0;
            bit_idx  <= '0;
        end else begin
            state    <= state_d;
            acc      <= acc_d;
            n_q      <= n_d;
            base_q   <= base_d;
            result_q <= result_d;
            exp_q    <= exp_d;
            bit_idx  <= bit_idx_d;
        end
    end

    always_comb begin
        state_d   = state;
        acc_d     = acc;
        n_d       = n_q;
        base_d    = base_q;
        result_d  = result_q;
        exp_d     = exp_q;
        bit_idx_d = bit_idx;

        case (state)
            IDLE: begin
                if (bus.i_start) begin
                    n_d    = bus.i_n;
                    base_d = bus.i_base;
                    exp_d  = bus.i_exp;
`ifdef MODEXP_SKIP_LZ_EN
                    if (!hi_found) begin
                        acc_d    = WIDTH'(1);
                        result_d = WIDTH'(1);
                        state_d  = DONE;
                    end else if (hi_idx == '0) begin
                        acc_d    = bus.i_base;
                        result_d = bus.i_base;
                        state_d  = DONE;
                    end else begin
                        acc_d     = bus.i_base;
                        bit_idx_d = hi_idx - 1'b1;
                        state_d   = SQ_ISSUE;
                    end
`else
                    acc_d     = WIDTH'(1);
                    bit_idx_d = IDX_W'(EXP_BITS - 1);
                    state_d   = SQ_ISSUE;
`endif
                end
            end

            SQ_ISSUE: state_d = SQ_WAIT;

            SQ_WAIT: begin
                if (bus.i_mul_finished) begin
                    acc_d = bus.i_mul_result;
                    if (exp_q[bit_idx]) begin
                        state_d = MUL_ISSUE;
                    end else if (bit_idx == '0) begin
                        result_d = bus.i_mul_result;
                        state_d  = DONE;
                    end else begin
                        bit_idx_d = bit_idx - 1'b1;
                        state_d   = SQ_ISSUE;
                    end
                end
            end

            MUL_ISSUE: state_d = MUL_WAIT;

            MUL_WAIT: begin
                if (bus.i_mul_finished) begin
                    acc_d = bus.i_mul_result;
                    if (bit_idx == '0) begin
                        result_d = bus.i_mul_result;
                        state_d  = DONE;
                    end else begin
                        bit_idx_d = bit_idx - 1'b1;
                        state_d   = SQ_ISSUE;
                    end
                end
            end

            DONE: state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    // Operands are decoded from registers that only change when the multiplier reports done,
    // so they stay stable across each issue/wait pair.
    assign bus.o_busy      = (state != IDLE);
    assign bus.o_finished  = (state == DONE);
    assign bus.o_mul_start = (state == SQ_ISSUE) || (state == MUL_ISSUE);
    assign bus.o_mul_a     = acc;
    assign bus.o_mul_b     = ((state == MUL_ISSUE) || (state == MUL_WAIT)) ? base_q : acc;
    assign bus.o_mul_n     = n_q;
    assign bus.o_result    = result_q;
endmodule

// File: tb/tb_mod_exp_sequencer.sv
// Randomised scoreboard bench for mod_exp_sequencer with a fixed-latency multiplier model.
module tb_mod_exp_sequencer;
    localparam int unsigned W  = 8;
    localparam int unsigned EB = 8;
    localparam int unsigned L  = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mod_exp_sequencer_if #(.WIDTH(W), .EXP_BITS(EB)) bus ();

    mod_exp_sequencer #(.WIDTH(W), .EXP_BITS(EB)) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] res;
        int unsigned  fin_cyc;
        int unsigned  pulses;
    } exp_t;

    exp_t         sb[$];
    int unsigned  tests     = 0;
    int unsigned  fails     = 0;
    int unsigned  cyc       = 0;
    int unsigned  pulse_cnt = 0;
    logic [W-1:0] last_res  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Multiplier model: result presented L cycles after the start pulse
    logic         mf   = 1'b0;
    logic         spur = 1'b0;
    logic [W-1:0] mres = '0;
    logic [W-1:0] la, lb, ln;
    int unsigned  cnt  = 0;
    bit           act  = 1'b0;

    assign bus.i_mul_finished = mf | spur;
    assign bus.i_mul_result   = mres;

    always @(negedge clk) begin
        if (!rst_n) begin
            act = 1'b0;
            mf  = 1'b0;
        end else begin
            if (mf) mf = 1'b0;
            if (act) begin
                check("operand_hold", {bus.o_mul_a, bus.o_mul_b, bus.o_mul_n}, {la, lb, ln});
                cnt--;
                if (cnt == 0) begin
                    mres = (ln == 0) ? '0 : W'((int'(la) * int'(lb)) % int'(ln));
                    mf   = 1'b1;
                    act  = 1'b0;
                end
            end else if (bus.o_mul_start) begin
                la  = bus.o_mul_a;
                lb  = bus.o_mul_b;
                ln  = bus.o_mul_n;
                cnt = L;
                act = 1'b1;
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            pulse_cnt = 0;
            last_res  = '0;
        end else begin
            if (bus.o_mul_start) pulse_cnt++;
            if (bus.o_finished) begin
                if (sb.size() == 0) begin
                    check("unexpected_finished", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("result", bus.o_result, e.res);
                    check("finish_cycle", cyc, e.fin_cyc);
                    check("mul_start_pulses", pulse_cnt, e.pulses);
                    last_res = e.res;
                end
                pulse_cnt = 0;
            end else if (bus.o_busy && bus.o_mul_start) begin
                check("result_hold", bus.o_result, last_res);
            end
        end
    end

    function automatic logic [W-1:0] ref_pow(input int unsigned n, input int unsigned b,
                                             input int unsigned e);
        int unsigned r = 1;
        for (int unsigned i = 0; i < e; i++) r = (r * b) % n;
        return W'(r);
    endfunction

    function automatic int unsigned ops_for(input logic [EB-1:0] e);
        int unsigned pop = $countones(e);
`ifdef MODEXP_SKIP_LZ_EN
        int unsigned h = 0;
        if (e <= 1) return 0;
        for (int unsigned i = 0; i < EB; i++) if (e[i]) h = i;
        return h + pop - 1;
`else
        return EB + pop;
`endif
    endfunction

    task automatic drive_start(input logic [W-1:0] n, input logic [W-1:0] b,
                               input logic [EB-1:0] e, input bit expect_done);
        exp_t it;
        @(posedge clk); #1;
        bus.i_start = 1'b1;
        bus.i_n     = n;
        bus.i_base  = b;
        bus.i_exp   = e;
        if (expect_done) begin
            it.res     = ref_pow(n, b, e);
            it.pulses  = ops_for(e);
            it.fin_cyc = cyc + it.pulses * (L + 1) + 1;
            sb.push_back(it);
        end
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        bus.i_n     = W'($urandom);
        bus.i_base  = W'($urandom);
        bus.i_exp   = EB'($urandom);
    endtask

    task automatic run(input logic [W-1:0] n, input logic [W-1:0] b, input logic [EB-1:0] e,
                       input bit spurious, input bit busy_poke);
        int unsigned k = 0;
        drive_start(n, b, e, 1'b1);
        if (spurious) begin
            spur = 1'b1;
            @(posedge clk); #1;
            spur = 1'b0;
        end
        if (busy_poke) begin
            repeat (20) @(posedge clk);
            #1;
            bus.i_start = 1'b1;
            @(posedge clk); #1;
            bus.i_start = 1'b0;
        end
        while (sb.size() != 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("completion_timeout", sb.size(), 0);
        sb.delete();
        @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, bus.o_busy, 0);
        check({tag, "_finished"}, bus.o_finished, 0);
        check({tag, "_mul_start"}, bus.o_mul_start, 0);
        check({tag, "_mul_a"}, bus.o_mul_a, 0);
        check({tag, "_mul_b"}, bus.o_mul_b, 0);
        check({tag, "_mul_n"}, bus.o_mul_n, 0);
        check({tag, "_result"}, bus.o_result, 0);
    endtask

    initial begin
        int unsigned k;
        logic [W-1:0] rn, rb;
        bus.i_start = 1'b0;
        bus.i_n     = '0;
        bus.i_base  = '0;
        bus.i_exp   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;

        run(8'd7,   8'd3, 8'd5,   1'b0, 1'b0);
        run(8'd251, 8'd2, 8'hFF,  1'b1, 1'b1);
        run(8'd13,  8'd9, 8'd0,   1'b0, 1'b0);
        run(8'd11,  8'd6, 8'd1,   1'b0, 1'b0);
        run(8'd11,  8'd6, 8'd2,   1'b1, 1'b0);

        // Abort in MUL_WAIT: no finished pulse may follow
        drive_start(8'd7, 8'd3, 8'd5, 1'b0);
        k = 0;
        while (!(bus.o_mul_start && (bus.o_mul_a != bus.o_mul_b)) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("reach_mul_issue", k < 2000, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_reset_outputs("abort");
        repeat (30) @(posedge clk);
        run(8'd7, 8'd3, 8'd5, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            rn = W'($urandom_range(255, 2));
            rb = W'($urandom_range(int'(rn) - 1, 0));
            run(rn, rb, EB'($urandom_range(255, 0)), 1'(i % 3 == 0), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
